// File: rtl/modbus_rx_frame_module.sv
// Receive-side Modbus RTU framer: 8N1 UART deserialiser feeding a fixed
// 7-byte frame assembler (addr, func, 3 data, CRC lo, CRC hi) with
// address, stop-bit, CRC-16/Modbus and inter-character gap checking.
module modbus_rx_frame_module #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter logic [7:0]  DEV_ADDR     = 8'h02,
  parameter int unsigned GAP_BITS     = 35
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX_En_Sig,
  input  logic        RX_Pin_In,
  output logic        RX_Done_Sig,
  output logic [7:0]  RX_Func,
  output logic [23:0] RX_Data,
  output logic        RX_Err_Sig,
  output logic [1:0]  RX_Err_Code
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_BIT  = CLKS_PER_BIT / 2;
  localparam int unsigned GAP_LIM   = GAP_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W     = $clog2(GAP_LIM + 1);
  localparam int unsigned FRAME_LEN = 7;

  localparam logic [1:0] ERR_FRAMING = 2'd1;
  localparam logic [1:0] ERR_CRC     = 2'd2;
  localparam logic [1:0] ERR_GAP     = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  rx_state_t         state;
  rx_state_t         state_next;

  logic              sync_q1;
  logic              sync_q2;
  logic              sync_prev;
  logic              fall_c;

  logic [CNT_W-1:0]  bit_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift_reg;
  logic              full_bit_c;
  logic              half_bit_c;
  logic              bit_tick_c;
  logic              byte_ok_c;
  logic              frame_err_c;

  logic [2:0]        byte_cnt;
  logic [15:0]       crc_q;
  logic [3:0]        crc_shift;
  logic [GAP_W-1:0]  gap_cnt;
  logic [7:0]        addr_q;
  logic [7:0]        func_q;
  logic [23:0]       data_q;

  // One reflected CRC-16/Modbus shift (poly 0xA001)
  function automatic logic [15:0] crc_step(input logic [15:0] c);
    return c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
  endfunction

  // Two-flop synchroniser plus edge register on the async RX line
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      sync_prev <= 1'b1;
    end else begin
      sync_q1   <= RX_Pin_In;
      sync_q2   <= sync_q1;
      sync_prev <= sync_q2;
    end
  end

  assign fall_c     = sync_prev & ~sync_q2;
  assign full_bit_c = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign half_bit_c = (bit_cnt == CNT_W'(HALF_BIT - 1));

  // Bit FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Bit FSM next state and per-cycle strobes
  always_comb begin
    state_next  = state;
    bit_tick_c  = 1'b0;
    byte_ok_c   = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall_c) state_next = ST_START;
      end
      ST_START: begin
        if (half_bit_c) begin
          bit_tick_c = 1'b1;
          state_next = sync_q2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (full_bit_c) begin
          bit_tick_c = 1'b1;
          if (bit_idx == 3'd7) state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (full_bit_c) begin
          bit_tick_c = 1'b1;
          if (sync_q2) begin
            byte_ok_c  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_err_c = 1'b1;
            state_next  = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (sync_q2) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (!RX_En_Sig) begin
      state_next  = ST_IDLE;
      bit_tick_c  = 1'b0;
      byte_ok_c   = 1'b0;
      frame_err_c = 1'b0;
    end
  end

  // Bit-time counter, restarted at every sample point and while idle
  always_ff @(posedge CLK) begin
    if (RST || !RX_En_Sig || state == ST_IDLE || state == ST_BREAK || bit_tick_c)
      bit_cnt <= '0;
    else
      bit_cnt <= bit_cnt + CNT_W'(1);
  end

  // LSB-first data shift register and bit index
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_idx   <= '0;
      shift_reg <= '0;
    end else if (state == ST_IDLE) begin
      bit_idx <= '0;
    end else if (state == ST_DATA && bit_tick_c) begin
      shift_reg <= {sync_q2, shift_reg[7:1]};
      bit_idx   <= bit_idx + 3'd1;
    end
  end

  // Frame assembly, CRC engine, gap timer and result pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_cnt    <= '0;
      crc_q       <= 16'hFFFF;
      crc_shift   <= '0;
      gap_cnt     <= '0;
      addr_q      <= '0;
      func_q      <= '0;
      data_q      <= '0;
      RX_Done_Sig <= 1'b0;
      RX_Err_Sig  <= 1'b0;
      RX_Err_Code <= '0;
      RX_Func     <= '0;
      RX_Data     <= '0;
    end else begin
      RX_Done_Sig <= 1'b0;
      RX_Err_Sig  <= 1'b0;
      if (!RX_En_Sig) begin
        byte_cnt  <= '0;
        crc_shift <= '0;
        gap_cnt   <= '0;
      end else begin
        if (crc_shift != 4'd0) begin
          crc_q     <= crc_step(crc_q);
          crc_shift <= crc_shift - 4'd1;
        end

        if (byte_ok_c) begin
          // First byte of a frame restarts the CRC from the preset
          crc_q     <= ((byte_cnt == 3'd0) ? 16'hFFFF : crc_q) ^ {8'h00, shift_reg};
          crc_shift <= 4'd8;
          byte_cnt  <= byte_cnt + 3'd1;
          gap_cnt   <= '0;
          case (byte_cnt)
            3'd0:    addr_q         <= shift_reg;
            3'd1:    func_q         <= shift_reg;
            3'd2:    data_q[23:16]  <= shift_reg;
            3'd3:    data_q[15:8]   <= shift_reg;
            3'd4:    data_q[7:0]    <= shift_reg;
            default: ;
          endcase
        end else if (frame_err_c) begin
          RX_Err_Sig  <= 1'b1;
          RX_Err_Code <= ERR_FRAMING;
          byte_cnt    <= '0;
          gap_cnt     <= '0;
        end else if (byte_cnt == 3'(FRAME_LEN) && crc_shift == 4'd0) begin
          // Residual zero after the CRC bytes means the frame is intact
          byte_cnt <= '0;
          if (crc_q != 16'h0000) begin
            RX_Err_Sig  <= 1'b1;
            RX_Err_Code <= ERR_CRC;
          end else if (addr_q == DEV_ADDR) begin
            RX_Done_Sig <= 1'b1;
            RX_Func     <= func_q;
            RX_Data     <= data_q;
          end
        end else if (state == ST_IDLE && byte_cnt != 3'd0 && byte_cnt < 3'(FRAME_LEN)) begin
          // A start edge wins over a coincident timeout
          if (fall_c) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_W'(GAP_LIM - 1)) begin
            RX_Err_Sig  <= 1'b1;
            RX_Err_Code <= ERR_GAP;
            byte_cnt    <= '0;
            gap_cnt     <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_modbus_rx_frame_module.sv
// Self-checking bench for modbus_rx_frame_module: byte-level frame model
// with an event scoreboard, checked against the DUT on every cycle.
module tb_modbus_rx_frame_module;

  localparam int unsigned CPB      = 16;
  localparam int unsigned GAP_BITS = 35;
  localparam int unsigned GAP_LIM  = GAP_BITS * CPB;
  // Pin drive (just after edge c0) to stop-sample edge: 3 sync/edge + half bit + 9 bits
  localparam int unsigned STOP_OFS = 3 + CPB / 2 + 9 * CPB;
  localparam logic [7:0]  ADDR     = 8'h02;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RX_En_Sig = 1'b1;
  logic        RX_Pin_In = 1'b1;
  logic        RX_Done_Sig;
  logic [7:0]  RX_Func;
  logic [23:0] RX_Data;
  logic        RX_Err_Sig;
  logic [1:0]  RX_Err_Code;

  modbus_rx_frame_module #(
    .CLKS_PER_BIT(CPB),
    .DEV_ADDR    (ADDR),
    .GAP_BITS    (GAP_BITS)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_En_Sig  (RX_En_Sig),
    .RX_Pin_In  (RX_Pin_In),
    .RX_Done_Sig(RX_Done_Sig),
    .RX_Func    (RX_Func),
    .RX_Data    (RX_Data),
    .RX_Err_Sig (RX_Err_Sig),
    .RX_Err_Code(RX_Err_Code)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    int unsigned at;
    bit          is_done;
    logic [1:0]  code;
    logic [7:0]  func;
    logic [23:0] data;
  } ev_t;

  ev_t         exp_q[$];
  bytes_t      part_q;
  bit          to_pending = 1'b0;
  int unsigned to_at = 0;
  logic [7:0]  m_func = 8'h00;
  logic [23:0] m_data = 24'h000000;
  bit          checking = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done_seen = 0;
  logic [1:0]  last_err_code = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input bytes_t q);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bytes_t make_frame(input logic [7:0] a, input logic [7:0] fn, input logic [23:0] d);
    bytes_t q;
    logic [15:0] c;
    q.push_back(a);
    q.push_back(fn);
    q.push_back(d[23:16]);
    q.push_back(d[15:8]);
    q.push_back(d[7:0]);
    c = crc16(q);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  // Model: account for one byte whose start bit is driven now
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int unsigned d;
    int unsigned s;
    ev_t ev;
    bytes_t body;
    d = cyc + 3;
    s = cyc + STOP_OFS;
    if (to_pending) begin
      if (d <= to_at) void'(exp_q.pop_back());
      else part_q.delete();
      to_pending = 1'b0;
    end
    ev.func = 8'h00;
    ev.data = 24'h000000;
    ev.code = 2'd0;
    ev.is_done = 1'b0;
    if (!stop_ok) begin
      ev.at = s;
      ev.code = 2'd1;
      exp_q.push_back(ev);
      part_q.delete();
    end else begin
      part_q.push_back(b);
      if (part_q.size() == 7) begin
        for (int i = 0; i < 5; i++) body.push_back(part_q[i]);
        ev.at = s + 9;
        if (crc16(body) != {part_q[6], part_q[5]}) begin
          ev.code = 2'd2;
          exp_q.push_back(ev);
        end else if (part_q[0] == ADDR) begin
          ev.is_done = 1'b1;
          ev.func = part_q[1];
          ev.data = {part_q[2], part_q[3], part_q[4]};
          exp_q.push_back(ev);
        end
        part_q.delete();
      end else begin
        ev.at = s + GAP_LIM;
        ev.code = 2'd3;
        exp_q.push_back(ev);
        to_pending = 1'b1;
        to_at = ev.at;
      end
    end
  endtask

  // Model: partial frame thrown away (reset or disable)
  task automatic model_abort(input bit clear_outputs);
    if (to_pending) void'(exp_q.pop_back());
    to_pending = 1'b0;
    part_q.delete();
    if (clear_outputs) begin
      m_func = 8'h00;
      m_data = 24'h000000;
    end
  endtask

  task automatic drive_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX_Pin_In = fr[i];
      repeat (CPB) @(negedge CLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    drive_byte(b, stop_ok);
  endtask

  task automatic idle_bits(input int unsigned n);
    RX_Pin_In = 1'b1;
    repeat (n * CPB) @(negedge CLK);
  endtask

  task automatic send_frame(input bytes_t f, input int unsigned gapmax);
    foreach (f[i]) begin
      send_byte(f[i], 1'b1);
      if (gapmax != 0) idle_bits($urandom_range(0, gapmax));
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge CLK);
    check(name, exp_q.size(), 0);
    idle_bits(1);
  endtask

  // Per-cycle compare of DUT pulses and held outputs against the scoreboard
  always @(negedge CLK) begin : cmp
    ev_t ev;
    bit ed;
    bit ee;
    logic [1:0] ec;
    if (checking && !RST) begin
      ed = 1'b0;
      ee = 1'b0;
      ec = 2'd0;
      while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_event cyc=%0d got=none expected_at=%0d", cyc, exp_q[0].at);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
        ev = exp_q.pop_front();
        if (ev.is_done) begin
          ed = 1'b1;
          m_func = ev.func;
          m_data = ev.data;
        end else begin
          ee = 1'b1;
          ec = ev.code;
        end
      end
      check("done_pulse", RX_Done_Sig, ed);
      check("err_pulse", RX_Err_Sig, ee);
      if (ee) check("err_code", RX_Err_Code, ec);
      check("func_out", RX_Func, m_func);
      check("data_out", RX_Data, m_data);
      if (RX_Done_Sig) n_done_seen++;
      if (RX_Err_Sig) last_err_code = RX_Err_Code;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bytes_t f;
    logic [7:0]  fn;
    logic [23:0] dd;
    logic [7:0]  ad;
    int unsigned n;
    bit trunc;

    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("rst_done", RX_Done_Sig, 0);
    check("rst_err", RX_Err_Sig, 0);
    check("rst_code", RX_Err_Code, 0);
    check("rst_func", RX_Func, 8'h00);
    check("rst_data", RX_Data, 24'h000000);
    checking = 1'b1;
    idle_bits(2);

    // Known-good frame 02 02 00 00 05 9C 7B
    f = make_frame(8'h02, 8'h02, 24'h000005);
    check("model_crc_lo", f[5], 8'h9C);
    check("model_crc_hi", f[6], 8'h7B);
    send_frame(f, 0);
    drain("drain_valid");
    check("valid_done_count", n_done_seen, 1);
    check("valid_func", RX_Func, 8'h02);
    check("valid_data", RX_Data, 24'h000005);

    // Corrupt CRC high byte: error 2, outputs unchanged
    f[6] = 8'h7A;
    send_frame(f, 0);
    drain("drain_badcrc");
    check("badcrc_code", last_err_code, 2);
    check("badcrc_done_count", n_done_seen, 1);
    check("badcrc_func", RX_Func, 8'h02);
    check("badcrc_data", RX_Data, 24'h000005);

    // Foreign address is silent, next frame still decodes
    f = make_frame(8'h03, 8'h02, 24'h000005);
    send_frame(f, 0);
    fn = 8'($urandom);
    dd = 24'($urandom);
    f = make_frame(ADDR, fn, dd);
    send_frame(f, 2);
    drain("drain_foreign");
    check("foreign_done_count", n_done_seen, 2);
    check("after_foreign_func", RX_Func, fn);
    check("after_foreign_data", RX_Data, dd);

    // Truncated frame then 36 idle bit-times: gap timeout
    send_byte(8'h02, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    idle_bits(36);
    drain("drain_gap");
    check("gap_code", last_err_code, 3);
    f = make_frame(ADDR, 8'h10, 24'h123456);
    send_frame(f, 0);
    drain("drain_after_gap");
    check("after_gap_data", RX_Data, 24'h123456);

    // Stop bit low: framing error, line held low, then clean restart
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge CLK);
    idle_bits(2);
    drain("drain_framing");
    check("framing_code", last_err_code, 1);
    f = make_frame(ADDR, 8'h06, 24'hA5A5A5);
    send_frame(f, 1);
    drain("drain_after_framing");
    check("after_framing_func", RX_Func, 8'h06);

    // Short low glitch on the idle line
    RX_Pin_In = 1'b0;
    repeat (4) @(negedge CLK);
    idle_bits(3);
    drain("drain_glitch");

    // Reset during byte 3 of a frame
    f = make_frame(ADDR, 8'h21, 24'h0F0F0F);
    for (int i = 0; i < 3; i++) send_byte(f[i], 1'b1);
    RST = 1'b1;
    model_abort(1'b1);
    for (int i = 3; i < 7; i++) drive_byte(f[i], 1'b1);
    RX_Pin_In = 1'b1;
    RST = 1'b0;
    @(negedge CLK);
    check("midrst_func", RX_Func, 8'h00);
    check("midrst_data", RX_Data, 24'h000000);
    idle_bits(2);
    send_frame(f, 0);
    drain("drain_after_rst");
    check("after_rst_data", RX_Data, 24'h0F0F0F);

    // Receiver disabled mid-frame
    f = make_frame(ADDR, 8'h33, 24'h777777);
    for (int i = 0; i < 3; i++) send_byte(f[i], 1'b1);
    RX_En_Sig = 1'b0;
    model_abort(1'b0);
    repeat (5) @(negedge CLK);
    RX_En_Sig = 1'b1;
    idle_bits(1);
    send_frame(f, 0);
    drain("drain_after_disable");
    check("after_disable_func", RX_Func, 8'h33);

    // Randomised frames: foreign addresses, corrupted CRC, truncation
    for (int fr_i = 0; fr_i < 12; fr_i++) begin
      ad = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ADDR;
      fn = 8'($urandom);
      dd = 24'($urandom);
      f = make_frame(ad, fn, dd);
      if ($urandom_range(0, 3) == 0) f[5 + $urandom_range(0, 1)] ^= 8'(1 << $urandom_range(0, 7));
      trunc = ($urandom_range(0, 4) == 0);
      n = trunc ? $urandom_range(1, 6) : 7;
      for (int i = 0; i < int'(n); i++) begin
        send_byte(f[i], 1'b1);
        if (i < int'(n) - 1) idle_bits($urandom_range(0, 3));
      end
      if (trunc) idle_bits(36);
      else idle_bits($urandom_range(0, 4));
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
